// File: rtl/data_bus_latch.sv
// rtl/data_bus_latch.sv - data latch, data output register and PHI1/PHI2 bus cycle
// Define DL_PRECHARGE_EN to make undriven internal buses read all-ones.
module data_bus_latch #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rw,
  input  logic          rdy,
  input  logic [DW-1:0] ext_data_in,
  output logic [DW-1:0] ext_data_out,
  output logic          ext_data_oe,
  input  logic [DW-1:0] db_in,
  input  logic          dor_load,
  input  logic          dl_to_db,
  input  logic          dl_to_adl,
  input  logic          dl_to_adh,
  output logic [DW-1:0] db_out,
  output logic [DW-1:0] adl_out,
  output logic [DW-1:0] adh_out,
  output logic          db_drv,
  output logic          adl_drv,
  output logic          adh_drv,
  output logic          phi2,
  output logic          stall
);

  typedef enum logic {PHI1 = 1'b0, PHI2 = 1'b1} phase_t;

`ifdef DL_PRECHARGE_EN
  localparam logic [DW-1:0] UNDRV = '1;
`else
  localparam logic [DW-1:0] UNDRV = '0;
`endif

  phase_t        phase_q, phase_d;
  logic          rw_q, rw_d;
  logic [DW-1:0] dl_q, dl_d;
  logic [DW-1:0] dor_q, dor_d;
  logic          in_phi2;

  always_comb begin
    in_phi2 = (phase_q == PHI2);
    stall   = in_phi2 & rw_q & ~rdy;
    phase_d = phase_q;
    rw_d    = rw_q;
    dl_d    = dl_q;
    dor_d   = dor_q;
    if (!in_phi2) begin
      phase_d = PHI2;
      rw_d    = rw;
      if (dor_load) dor_d = db_in;
    end else if (!stall) begin
      // Writes never stall; reads close here and capture the pins.
      phase_d = PHI1;
      if (rw_q) dl_d = ext_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PHI1;
      rw_q    <= 1'b1;
      dl_q    <= '0;
      dor_q   <= '0;
    end else begin
      phase_q <= phase_d;
      rw_q    <= rw_d;
      dl_q    <= dl_d;
      dor_q   <= dor_d;
    end
  end

  // Pin enable decoded from flops only so it cannot glitch.
  assign ext_data_oe  = in_phi2 & ~rw_q;
  assign ext_data_out = dor_q;
  assign phi2         = in_phi2;

  assign db_drv  = dl_to_db;
  assign adl_drv = dl_to_adl;
  assign adh_drv = dl_to_adh;
  assign db_out  = dl_to_db  ? dl_q : UNDRV;
  assign adl_out = dl_to_adl ? dl_q : UNDRV;
  assign adh_out = dl_to_adh ? dl_q : UNDRV;

endmodule

// File: tb/tb_data_bus_latch.sv
// tb/tb_data_bus_latch.sv - directed and random checks of data_bus_latch against a bus-cycle model
module tb_data_bus_latch;

`ifdef DL_PRECHARGE_EN
  localparam logic [7:0] UND = 8'hFF;
`else
  localparam logic [7:0] UND = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rw = 1'b1, rdy = 1'b1, dor_load = 1'b0;
  logic       dl_to_db = 1'b0, dl_to_adl = 1'b0, dl_to_adh = 1'b0;
  logic [7:0] ext_data_in = 8'h00, db_in = 8'h00;
  logic [7:0] ext_data_out, db_out, adl_out, adh_out;
  logic       ext_data_oe, db_drv, adl_drv, adh_drv, phi2, stall;

  data_bus_latch #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .rw(rw), .rdy(rdy),
    .ext_data_in(ext_data_in), .ext_data_out(ext_data_out), .ext_data_oe(ext_data_oe),
    .db_in(db_in), .dor_load(dor_load),
    .dl_to_db(dl_to_db), .dl_to_adl(dl_to_adl), .dl_to_adh(dl_to_adh),
    .db_out(db_out), .adl_out(adl_out), .adh_out(adh_out),
    .db_drv(db_drv), .adl_drv(adl_drv), .adh_drv(adh_drv),
    .phi2(phi2), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: which half of the bus cycle we are in, the direction latched
  // for this cycle, the last byte read from the pins and the byte to write.
  bit       m_in_phi2;
  bit       m_is_read;
  bit [7:0] m_dl;
  bit [7:0] m_dor;
  logic [7:0] saved;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_in_phi2 = 0; m_is_read = 1; m_dl = 8'h00; m_dor = 8'h00;
  endtask

  function automatic logic [7:0] bus_val(input logic en);
    return en ? m_dl : UND;
  endfunction

  task automatic compare_all();
    chk("phi2",  phi2, m_in_phi2);
    chk("stall", stall, m_in_phi2 && m_is_read && !rdy);
    chk("oe",    ext_data_oe, m_in_phi2 && !m_is_read);
    chk("dout",  ext_data_out, m_dor);
    chk("db",    db_out,  bus_val(dl_to_db));
    chk("adl",   adl_out, bus_val(dl_to_adl));
    chk("adh",   adh_out, bus_val(dl_to_adh));
    chk("drv",   {db_drv, adl_drv, adh_drv}, {dl_to_db, dl_to_adl, dl_to_adh});
  endtask

  // One clock of the bus cycle as described at the behavioural level.
  task automatic model_clock();
    if (!m_in_phi2) begin
      m_is_read = rw;
      if (dor_load) m_dor = db_in;
      m_in_phi2 = 1;
    end else if (m_is_read && !rdy) begin
      // held in PHI2
    end else begin
      if (m_is_read) m_dl = ext_data_in;
      m_in_phi2 = 0;
    end
  endtask

  // Inputs are set at the falling edge; outputs compared 1ns later.
  task automatic cyc();
    #1 compare_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic to_phi1();
    for (int i = 0; i < 4 && m_in_phi2; i++) begin
      rdy = 1'b1; dor_load = 1'b0;
      cyc();
    end
    chk("to_phi1", phi2, 1'b0);
  endtask

  initial begin
    model_reset();
    @(negedge clk); @(negedge clk);
    #1 compare_all();
    rst_n = 1'b1;

    // Read of 0xA5 onto DB only
    to_phi1();
    rw = 1; rdy = 1; dl_to_db = 1; dl_to_adl = 0; dl_to_adh = 0;
    cyc();
    ext_data_in = 8'hA5;
    cyc();
    #1 chk("read_db", db_out, 8'hA5);
    chk("read_adl", adl_out, UND);

    // Write of 0x3C
    to_phi1();
    rw = 0; dor_load = 1; db_in = 8'h3C;
    cyc();
    dor_load = 0;
    #1 chk("wr_oe_on", ext_data_oe, 1'b1);
    chk("wr_dout", ext_data_out, 8'h3C);
    cyc();
    #1 chk("wr_oe_off", ext_data_oe, 1'b0);
    chk("wr_dout_hold", ext_data_out, 8'h3C);

    // Read stalled three clocks; rw wiggles during PHI2 with no effect
    to_phi1();
    rw = 1; rdy = 0; dl_to_db = 1;
    saved = db_out;
    cyc();
    for (int i = 0; i < 3; i++) begin
      ext_data_in = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : 8'h5A;
      if (i == 1) rw = 0;
      #1 chk("stall_on", stall, 1'b1);
      chk("stall_phi2", phi2, 1'b1);
      chk("stall_dl", db_out, saved);
      cyc();
    end
    rdy = 1;
    cyc();
    #1 chk("stall_rel_dl", db_out, 8'h5A);
    chk("stall_rel_phi1", phi2, 1'b0);

    // Write ignores rdy
    to_phi1();
    rw = 0; rdy = 0;
    cyc();
    #1 chk("wr_nostall", stall, 1'b0);
    chk("wr_rdy_oe", ext_data_oe, 1'b1);
    cyc();
    #1 chk("wr_rdy_phi1", phi2, 1'b0);
    chk("wr_rdy_oe_off", ext_data_oe, 1'b0);

    // Multi-drive of 0x80
    rdy = 1;
    to_phi1();
    rw = 1; ext_data_in = 8'h80;
    cyc(); cyc();
    dl_to_db = 1; dl_to_adl = 1; dl_to_adh = 1;
    #1 chk("multi_out", {db_out, adl_out, adh_out}, 24'h808080);
    chk("multi_drv", {db_drv, adl_drv, adh_drv}, 3'b111);
    dl_to_adh = 0;
    #1 chk("drop_adh_drv", adh_drv, 1'b0);
    chk("drop_adh_out", adh_out, UND);
    cyc();

    // Reset asserted in PHI2 of a write
    to_phi1();
    rw = 0; dor_load = 1; db_in = 8'h77; dl_to_db = 1;
    cyc();
    dor_load = 0;
    #1 chk("rst_pre_oe", ext_data_oe, 1'b1);
    #2 rst_n = 0;
    #1 chk("rst_oe", ext_data_oe, 1'b0);
    chk("rst_phi2", phi2, 1'b0);
    chk("rst_dout", ext_data_out, 8'h00);
    chk("rst_dl", db_out, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1; rw = 1; rdy = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rst_toggle", phi2, (i % 2) == 1);
      cyc();
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rw          = $urandom_range(0, 1);
      rdy         = ($urandom_range(0, 3) != 0);
      dor_load    = $urandom_range(0, 1);
      db_in       = 8'($urandom);
      ext_data_in = 8'($urandom);
      dl_to_db    = $urandom_range(0, 1);
      dl_to_adl   = $urandom_range(0, 1);
      dl_to_adh   = $urandom_range(0, 1);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_latch.md
Name: data_bus_latch

Overview:
- Boundary between the external 8-bit data pins and the internal CPU buses: DB, ADL and ADH.
- Contains the input Data Latch (DL) and the Data Output Register (DOR).
- Generates an internal two-phase bus cycle, PHI1 then PHI2, with RDY stall support.
- Supplies the data and drive-enable values that the internal bus pass-switch network gates onto DB, ADL and ADH.

Parameters:
DW, 8, data width of the latch, the register and all buses.

Ports:
clk  input  1  system clock; one clk period per phase.
rst_n  input  1  asynchronous, active-low reset.
rw  input  1  1 = read cycle, 0 = write cycle; sampled at the end of PHI1.
rdy  input  1  ready; a low level stalls read cycles in PHI2.
ext_data_in  input  DW  external data pins (read direction).
ext_data_out  output  DW  external data pins (write direction) = DOR.
ext_data_oe  output  1  external pin output enable.
db_in  input  DW  internal data bus value loaded into DOR.
dor_load  input  1  load DOR from db_in.
dl_to_db  input  1  DL drives DB.
dl_to_adl  input  1  DL drives ADL.
dl_to_adh  input  1  DL drives ADH.
db_out, adl_out, adh_out  output  DW each  bus values.
db_drv, adl_drv, adh_drv  output  1 each  copies of the corresponding dl_to_* enables.
phi2  output  1  0 = PHI1, 1 = PHI2.
stall  output  1  a read is currently held in PHI2.

Behaviour:
- Registers: phase, rw_q, dl, dor. All are cleared asynchronously on rst_n low, in any state and mid-cycle:
  - phase = 0 (PHI1)
  - rw_q = 1 (read)
  - dl = 0x00
  - dor = 0x00
- Outputs during reset: ext_data_oe = 0 immediately, stall = 0, ext_data_out = 0x00.
- Phase FSM with two states, PHI1 and PHI2:
  - PHI1 -> PHI2 on every clk.
  - PHI2 -> PHI1 on clk unless a stall is active.
  - phi2 = phase.
- PHI1 edge (phase = 0):
  - rw_q <= rw.
  - If dor_load = 1: dor <= db_in, regardless of rw.
  - rdy is ignored.
- PHI2 edge (phase = 1):
  - stall = phase & rw_q & ~rdy (combinational).
  - Stall: phase holds PHI2; dl and rw_q hold.
  - Read, not stalled: dl <= ext_data_in; phase -> PHI1.
  - Write: rdy is ignored, there is never a stall, and dl holds.
  - dor_load is ignored in PHI2.
- ext_data_oe = phase & ~rw_q, from registers only, so it is glitch-free. It is asserted for exactly one clk per write cycle.
- ext_data_out = dor at all times.
- Read latency: ext_data_in sampled at the closing PHI2 edge is visible on db_out/adl_out/adh_out from the start of the next PHI1 (one clk).
- Bus outputs:
  - When dl_to_X = 1: X_out = dl.
  - When dl_to_X = 0: X_out = undriven value (see Optional Feature).
  - X_drv = dl_to_X (combinational, no latency).
- Enables are independent. Asserting any combination drives all selected buses with the same dl value; no arbitration.
- rw changing during PHI2 has no effect until the next PHI1 edge.
- rdy rising during a stall: the next edge captures ext_data_in and moves to PHI1.

Optional Feature:
- Macro: DL_PRECHARGE_EN.
- Defined: an undriven bus output reads 0xFF, modelling nMOS bus precharge.
- Not defined: an undriven bus output reads 0x00.
- In both cases X_drv reports the true drive state.

Test Plan:
- Reset: hold rst_n = 0 mid-PHI2 of a write -> ext_data_oe = 0 at once; phi2 = 0, dl = 0x00, ext_data_out = 0x00; after release, phi2 toggles every clk.
- Read: rw = 1, rdy = 1, ext_data_in = 0xA5 during PHI2, dl_to_db = 1 -> db_out = 0xA5 in the following PHI1; adl_out = 0x00, or 0xFF with DL_PRECHARGE_EN.
- Write: PHI1 with rw = 0, dor_load = 1, db_in = 0x3C -> next PHI2: ext_data_oe = 1, ext_data_out = 0x3C; next PHI1: ext_data_oe = 0, ext_data_out stays 0x3C.
- Read stall: rw = 1, rdy = 0 for 3 clks in PHI2 with ext_data_in stepping 0x11 -> 0x22 -> 0x5A -> stall = 1, phi2 = 1 and dl unchanged throughout; then rdy = 1 -> dl = 0x5A and phase returns to PHI1.
- Write ignores rdy: rw = 0, rdy = 0 -> PHI2 lasts one clk, stall = 0, ext_data_oe pulse is 1 clk.
- Multi-drive: dl = 0x80, dl_to_db = dl_to_adl = dl_to_adh = 1 -> all three outputs = 0x80 and all *_drv = 1; drop dl_to_adh -> adh_drv = 0 in the same cycle.
